// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg: shared widths, owner encoding and request bundle for the RAM arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/rr_wait_counter.sv
// ----------------------------------------------------------------------------
// rr_wait_counter: saturating count of port-1 refusals; raises force_win at MAX_WAIT.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_wait_counter #(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic force_win
);

  localparam logic [3:0] C_MAX = 4'(MAX_WAIT);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (req && !gnt) begin
      if (cnt != C_MAX) cnt <= cnt + 4'd1;
    end else begin
      cnt <= 4'd0;
    end
  end

  assign force_win = (cnt == C_MAX);

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter: shares one registered single-port RAM between two requesters.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ram_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int MAX_WAIT = 3
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [1:0]        owner
);

  mem_req_t          p0;
  mem_req_t          p1;
  mem_req_t          win;
  logic              granted;
  logic              force_win;
  owner_t            state;
  logic              rd0;
  logic              rd1;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;

  assign p0 = {m0_req, m0_we, m0_addr, m0_wdata};
  assign p1 = {m1_req, m1_we, m1_addr, m1_wdata};

  rr_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk       (CLK),
    .reset     (reset),
    .req       (m1_req),
    .gnt       (m1_gnt),
    .force_win (force_win)
  );

  // Port 0 has priority unless port 1 has been refused MAX_WAIT times in a row.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (p1.req && (!p0.req || force_win)) m1_gnt = 1'b1;
      else if (p0.req)                      m0_gnt = 1'b1;
    end
  end

  assign win     = m1_gnt ? p1 : p0;
  assign granted = m0_gnt | m1_gnt;

  assign ram_wren    = granted & win.req & win.we;
  assign ram_addr    = reset ? '0 : (granted ? win.addr  : last_addr);
  assign ram_data_in = reset ? '0 : (granted ? win.wdata : last_wdata);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      rd0        <= 1'b0;
      rd1        <= 1'b0;
      last_addr  <= '0;
      last_wdata <= '0;
      hold0      <= '0;
      hold1      <= '0;
    end else begin
      case (state)
        IDLE, OWN0, OWN1: state <= m0_gnt ? OWN0 : (m1_gnt ? OWN1 : IDLE);
        default:          state <= IDLE;
      endcase
      rd0 <= m0_gnt & ~m0_we;
      rd1 <= m1_gnt & ~m1_we;
      if (granted) begin
        last_addr  <= win.addr;
        last_wdata <= win.wdata;
      end
      if (rd0) hold0 <= ram_data_out;
      if (rd1) hold1 <= ram_data_out;
    end
  end

  // Read returns are masked during reset so an in-flight read never surfaces.
  assign m0_rvalid = rd0 & ~reset;
  assign m1_rvalid = rd1 & ~reset;
  assign m0_rdata  = rd0 ? ram_data_out : hold0;
  assign m1_rdata  = rd1 ? ram_data_out : hold1;
  assign owner     = state;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter: directed and random stimulus against a behavioural arbiter model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ram_arbiter;
  import mem_pkg::*;

  localparam int MAX_WAIT = 3;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [9:0]  m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_wren;
  logic [31:0] m0_rdata, m1_rdata, ram_data_in, ram_data_out;
  logic [9:0]  ram_addr;
  logic [1:0]  owner;

  ram_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .owner(owner)
  );

  always #5 CLK = ~CLK;

  // Registered RAM (read-first), preloaded with mem[i] = i * 0x11.
  logic [31:0] ram_mem [1024];
  logic        ram_ready = 1'b0;
  always @(posedge CLK) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= 32'(i) * 32'h11;
      ram_ready <= 1'b1;
    end else begin
      if (ram_wren) ram_mem[ram_addr] <= ram_data_in;
      ram_data_out <= ram_mem[ram_addr];
    end
  end

  // Reference model state
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mmem [1024];
  int          mwait = 0;
  logic        erv0 = 0, erv1 = 0, k0 = 0, k1 = 0;
  logic [31:0] erd0 = '0, erd1 = '0;
  logic [9:0]  mlast_addr = '0;
  owner_t      eown = IDLE;
  logic        last_g0 = 0, last_g1 = 0, obs_g1 = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1);
    logic       eg0, eg1;
    logic [9:0] eaddr;
    @(negedge CLK);
    reset = rst;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    eg1   = !rst && r1 && (!r0 || mwait == MAX_WAIT);
    eg0   = !rst && r0 && !eg1;
    eaddr = rst ? 10'd0 : (eg0 ? a0 : (eg1 ? a1 : mlast_addr));
    chk("m0_gnt", m0_gnt, eg0);
    chk("m1_gnt", m1_gnt, eg1);
    chk("ram_wren", ram_wren, (eg0 && w0) || (eg1 && w1));
    chk("ram_addr", ram_addr, eaddr);
    if (rst)      chk("ram_data_in_rst", ram_data_in, 32'd0);
    else if (eg0) chk("ram_data_in", ram_data_in, d0);
    else if (eg1) chk("ram_data_in", ram_data_in, d1);
    chk("m0_rvalid", m0_rvalid, rst ? 1'b0 : erv0);
    chk("m1_rvalid", m1_rvalid, rst ? 1'b0 : erv1);
    if (!rst) begin
      if (erv0 || k0) chk("m0_rdata", m0_rdata, erd0);
      if (erv1 || k1) chk("m1_rdata", m1_rdata, erd1);
      chk("owner", owner, eown);
      chk("wait_cnt", {28'd0, dut.u_wait.cnt}, mwait);
    end
    obs_g1  = m1_gnt;
    last_g0 = eg0;
    last_g1 = eg1;
    // Advance the model across the coming edge.
    if (rst) begin
      mwait = 0; erv0 = 0; erv1 = 0; k0 = 0; k1 = 0;
      eown = IDLE; mlast_addr = '0;
    end else begin
      erv0 = eg0 && !w0;
      erv1 = eg1 && !w1;
      if (erv0) begin erd0 = mmem[a0]; k0 = 1; end
      if (erv1) begin erd1 = mmem[a1]; k1 = 1; end
      if (eg0 && w0) mmem[a0] = d0;
      if (eg1 && w1) mmem[a1] = d1;
      if (r1 && !eg1) mwait = (mwait < MAX_WAIT) ? mwait + 1 : MAX_WAIT;
      else            mwait = 0;
      eown = eg0 ? OWN0 : (eg1 ? OWN1 : IDLE);
      if (eg0) mlast_addr = a0;
      if (eg1) mlast_addr = a1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 10'd0, 0, 0, 0, 10'd0, 0);
  endtask

  logic        act [2];
  logic        wr  [2];
  logic [9:0]  ad  [2];
  logic [31:0] dt  [2];
  logic [7:0]  seq;

  initial begin
    for (int i = 0; i < 1024; i++) mmem[i] = 32'(i) * 32'h11;

    // Reset held two cycles with both requesting, then port 0 wins on release.
    step(1, 1, 0, 10'd7, 0, 1, 0, 10'd9, 0);
    step(1, 1, 0, 10'd7, 0, 1, 0, 10'd9, 0);
    step(0, 1, 0, 10'd7, 0, 1, 0, 10'd9, 0);
    chk("release_m0_first", {31'd0, m0_gnt}, 32'd1);
    idle(3);

    // Port 0 alone: write then read back.
    step(0, 1, 1, 10'd5, 32'h000000AA, 0, 0, 10'd0, 0);
    step(0, 1, 0, 10'd5, 0,            0, 0, 10'd0, 0);
    step(0, 0, 0, 10'd0, 0,            0, 0, 10'd0, 0);
    chk("p0_readback", m0_rdata, 32'h000000AA);
    idle(1);

    // Continuous contention: expect 0,0,0,1,0,0,0,1.
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 10'(i + 20), 0, 1, 0, 10'(40 + (i / 4)), 0);
      seq = {seq[6:0], obs_g1};
    end
    chk("contention_seq", {24'd0, seq}, 32'h11);
    idle(2);

    // Pipelined port-1 reads of 1,2,3.
    step(0, 0, 0, 10'd0, 0, 1, 0, 10'd1, 0);
    step(0, 0, 0, 10'd0, 0, 1, 0, 10'd2, 0);
    step(0, 0, 0, 10'd0, 0, 1, 0, 10'd3, 0);
    step(0, 0, 0, 10'd0, 0, 0, 0, 10'd0, 0);
    step(0, 0, 0, 10'd0, 0, 0, 0, 10'd0, 0);
    step(0, 0, 0, 10'd0, 0, 0, 0, 10'd0, 0);
    chk("p1_last_read_held", m1_rdata, 32'h33);

    // Reset immediately after a granted read.
    step(0, 1, 0, 10'd2, 0, 0, 0, 10'd0, 0);
    step(1, 0, 0, 10'd0, 0, 0, 0, 10'd0, 0);
    step(0, 0, 0, 10'd0, 0, 0, 0, 10'd0, 0);
    chk("rst_mid_read_idle", {30'd0, owner}, {30'd0, IDLE});

    // Port 1 pulses while port 0 holds the grant, then cancels.
    step(0, 1, 0, 10'd4, 0, 1, 1, 10'd8, 32'hDEAD);
    step(0, 1, 0, 10'd4, 0, 0, 0, 10'd0, 0);
    step(0, 0, 0, 10'd0, 0, 0, 0, 10'd0, 0);
    chk("cancel_no_write", {22'd0, 10'd8}, 10'd8);
    idle(1);

    // Randomised traffic honouring the hold-until-grant rule.
    for (int p = 0; p < 2; p++) begin act[p] = 0; wr[p] = 0; ad[p] = '0; dt[p] = '0; end
    for (int c = 0; c < 800; c++) begin
      logic rst_now;
      for (int p = 0; p < 2; p++) begin
        logic dropped;
        dropped = 0;
        if (act[p] && !(p == 0 ? last_g0 : last_g1)) begin
          if ($urandom_range(0, 7) == 0) begin act[p] = 0; dropped = 1; end
        end else begin
          act[p] = 0;
        end
        if (!act[p] && !dropped && $urandom_range(0, 2) != 0) begin
          act[p] = 1;
          wr[p]  = 1'($urandom_range(0, 1));
          ad[p]  = 10'($urandom_range(0, 15));
          dt[p]  = $urandom;
        end
      end
      rst_now = ($urandom_range(0, 99) == 0);
      step(rst_now, act[0], wr[0], ad[0], dt[0], act[1], wr[1], ad[1], dt[1]);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters: port 0 is the core data port, port 1 is an auxiliary master (program/data loader, debug, DMA).
- Sits between `core_riscv` and `RAM`; the RAM-side pins connect 1:1 to the RAM instance.
- Issues at most one RAM access per cycle, returns read data one cycle later, and prevents starvation of port 1 with a bounded-wait counter.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DATA_W, 32, data width.
- MAX_WAIT, 3, consecutive cycles port 1 may be refused while requesting before it is forced to win (range 1..15).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  port 0 access request.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  ADDR_W  port 0 address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_gnt  out  1  port 0 access accepted this cycle.
- m0_rvalid  out  1  port 0 read data valid.
- m0_rdata  out  DATA_W  port 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- ram_wren  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_data_in  out  DATA_W  RAM write data.
- ram_data_out  in  DATA_W  RAM read data; registered RAM, valid one cycle after address.

Behaviour:
- **Reset** (reset=1 at edge):
  - state=IDLE, wait_cnt=0, both rvalid=0, rd_owner cleared.
  - While reset is held: gnt=0, ram_wren=0, ram_addr=0, ram_data_in=0.
  - A read granted in the cycle before reset yields no rvalid.
- **Grant logic**: combinational from req, state and wait_cnt. At most one gnt high per cycle; gnt never asserts without its req.
- **Arbitration order**:
  - Only one requests → it wins.
  - Both request and wait_cnt==MAX_WAIT → port 1 wins.
  - Both request otherwise → port 0 wins.
  - Neither requests → no grant; ram_wren=0, ram_addr holds its last value.
- **Access issue**:
  - In a grant cycle, ram_addr, ram_data_in and ram_wren (=winner we) come combinationally from the winner.
  - Writes complete at that edge.
- **Reads**:
  - rd_owner register captures the winner and we=0 at the edge.
  - Next cycle, the corresponding mX_rvalid=1 for exactly one cycle and mX_rdata=ram_data_out.
  - Latency = 1 cycle; back-to-back reads are fully pipelined, 1 per cycle.
- **rdata when not valid**: each mX_rdata holds its last valid value.
- **wait_cnt** (4-bit):
  - Increments when m1_req=1 and m1_gnt=0.
  - Clears when m1_gnt=1 or m1_req=0.
  - Saturates at MAX_WAIT.
- **State machine** (last owner, for debug/coverage): IDLE, OWN0, OWN1.
  - Next state = OWN0 if m0_gnt, OWN1 if m1_gnt, IDLE if no grant.
  - Every state reachable from every state.
- **Requester rule**: a requester must hold req and its payload stable until gnt. Dropping req before gnt is allowed and cancels the request with no RAM effect.
- **Simultaneous events**:
  - Write and read to the same address on consecutive cycles → read returns the new data (RAM ordering).
  - A forced port-1 win stalls port 0 for exactly that cycle.
- **Address width**: no translation; upper bits beyond ADDR_W are the requester's concern.

Decomposition:
- **Package `mem_pkg`**:
  - ADDR_W and DATA_W defaults.
  - Typedef `owner_t` enum {IDLE, OWN0, OWN1}.
  - Typedef `mem_req_t` struct {req, we, addr, wdata}.
- **Sub-module**: `rr_wait_counter`, the saturating starvation counter with a force output. Arbitration and the read-return pipeline stay in the top.

Test Plan:
- Reset: hold reset 2 cycles with both req=1 → gnt=0, ram_wren=0, rvalid=0; first cycle after release → m0_gnt=1.
- Port 0 alone: write 0x000000AA to addr 5, then read addr 5 → m0_gnt=1 both cycles, m0_rvalid=1 in the cycle after the read, m0_rdata=0x000000AA, m1 outputs quiet.
- Contention: both req=1 continuously, MAX_WAIT=3 → grant sequence 0,0,0,1,0,0,0,1; wait_cnt resets after each port-1 grant.
- Pipelined reads: port 1 alone reads addr 1,2,3 on consecutive cycles (RAM holds 0x11,0x22,0x33) → m1_rvalid high 3 consecutive cycles starting 1 cycle later with data 0x11,0x22,0x33.
- Reset mid-read: port 0 read granted, reset asserted next edge → m0_rvalid stays 0, state=IDLE.
- Idle and cancel: m1_req pulses 1 cycle while port 0 holds the grant, then drops → no m1_gnt, wait_cnt returns 0, no RAM write.
